// File: rtl/gpu_tex_pipe_ctrl_v3.sv
// gpu_tex_pipe_ctrl_v3: three-stage texel fetch pipeline (accept, tex-result, output)
// with an in-house texture-cache miss/refill/replay FSM and CLUT palette lookup.
module gpu_tex_pipe_ctrl_v3 #(
    parameter int ADR_W  = 19,
    parameter int COL_W  = 9,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [1:0]        GPU_REG_TexFormat,
    input  logic              GPU_TEX_DISABLE,
    input  logic              i_flushSpike,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        iPixelStateSpike,
    input  logic [9:0]        iScrX,
    input  logic [8:0]        iScrY,
    input  logic [COL_W-1:0]  iR,
    input  logic [COL_W-1:0]  iG,
    input  logic [COL_W-1:0]  iB,
    input  logic              iBGMSK,
    input  logic [1:0]        iUCoordLSB,
    input  logic [ADR_W-1:0]  iTexelAdr,
    output logic              o_texReq,
    output logic [ADR_W-1:0]  o_texAdr,
    input  logic              i_texHit,
    input  logic              i_texMiss,
    input  logic [15:0]       i_texData,
    output logic              o_fillReq,
    output logic [ADR_W-3:0]  o_fillAdr,
    input  logic              i_fillDone,
    output logic [7:0]        o_clutIndex,
    input  logic [15:0]       i_clutData,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [1:0]        oPixelStateSpike,
    output logic [9:0]        oScrX,
    output logic [8:0]        oScrY,
    output logic [COL_W-1:0]  oR,
    output logic [COL_W-1:0]  oG,
    output logic [COL_W-1:0]  oB,
    output logic              oBGMSK,
    output logic [15:0]       oTexel,
    output logic              oTransparent,
    output logic              o_busy,
    output logic [STAT_W-1:0] o_hitCnt,
    output logic [STAT_W-1:0] o_missCnt
);
    typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;
    state_t state, nextState;
    logic c1Valid, c1NoTex, c1Pend, c1Have, c1Msk;
    logic [1:0] c1Fmt, c1U, c1Spike, c2Spike;
    logic [9:0] c1X;
    logic [8:0] c1Y;
    logic [COL_W-1:0] c1R, c1G, c1B;
    logic [ADR_W-1:0] c1Adr;
    logic [15:0] c1Tex, c1Texel, c2Tex, c2Clut;
    logic c2NoTex, c2Pal, c2First;
    logic texHit, texMiss, c1Res, c1Adv, c2Adv, accept, replayReq;
    // A lookup result belongs to C1 only in the cycle after its request; both flags high counts as a miss.
    assign texHit    = c1Pend & i_texHit & !i_texMiss;
    assign texMiss   = c1Pend & i_texMiss;
    assign c1Texel   = c1Have ? c1Tex : i_texData;
    assign c1Res     = c1NoTex | c1Have | texHit;
    assign c2Adv     = !o_valid | i_ready;
    assign c1Adv     = (!c1Valid | c1Res) & c2Adv;
    assign o_ready   = c1Adv & (state == IDLE);
    assign accept    = i_valid & o_ready;
    assign replayReq = (state == REPLAY) & !c1Pend;
    assign o_texReq  = (accept & !GPU_TEX_DISABLE) | replayReq;
    assign o_texAdr  = (state == REPLAY) ? c1Adr : iTexelAdr;
    assign o_fillReq = (state == FILL);
    assign o_fillAdr = c1Adr[ADR_W-1:2];
    assign o_clutIndex = (c1Fmt == 2'd0) ? {4'h0, c1Texel[{c1U, 2'b00} +: 4]} :
                         (c1Fmt == 2'd1) ? (c1U[0] ? c1Texel[15:8] : c1Texel[7:0]) : 8'h00;
    // CLUT data arrives the cycle after load; afterwards the captured copy keeps oTexel stable.
    assign oTexel = c2NoTex ? 16'h7FFF : !c2Pal ? c2Tex : c2First ? i_clutData : c2Clut;
    assign oTransparent     = !c2NoTex & (oTexel[14:0] == 15'd0);
    assign oPixelStateSpike = i_flushSpike ? 2'b00 : c2Spike;
    assign o_busy           = c1Valid | o_valid;
    always_comb begin
        nextState = state;
        if (state == IDLE)
            nextState = texMiss ? FILL : IDLE;
        else if (state == FILL)
            nextState = i_fillDone ? REPLAY : FILL;
        else
            nextState = texMiss ? FILL : texHit ? IDLE : REPLAY;
    end
    always_ff @(posedge clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= nextState;
    end
    always_ff @(posedge clk) begin
        if (i_rst) begin
            c1Valid   <= 1'b0;
            c1Pend    <= 1'b0;
            c1Have    <= 1'b0;
            c1Spike   <= 2'b00;
            o_valid   <= 1'b0;
            c2First   <= 1'b0;
            c2Spike   <= 2'b00;
            o_hitCnt  <= '0;
            o_missCnt <= '0;
        end else begin
            if (c1Adv) begin
                c1Valid <= accept;
                c1Pend  <= accept & !GPU_TEX_DISABLE;
                c1Have  <= 1'b0;
                c1NoTex <= GPU_TEX_DISABLE;
                c1Fmt   <= GPU_REG_TexFormat;
                c1U     <= iUCoordLSB;
                c1Spike <= accept ? iPixelStateSpike : 2'b00;
                c1X     <= iScrX;
                c1Y     <= iScrY;
                c1R     <= iR;
                c1G     <= iG;
                c1B     <= iB;
                c1Msk   <= iBGMSK;
                c1Adr   <= iTexelAdr;
            end else begin
                c1Pend <= replayReq;
                if (texHit) begin
                    c1Have <= 1'b1;
                    c1Tex  <= i_texData;
                end
            end
            if (c2Adv) begin
                o_valid <= c1Valid & c1Res;
                c2Spike <= (c1Valid & c1Res) ? c1Spike : 2'b00;
                c2Tex   <= c1Texel;
                c2NoTex <= c1NoTex;
                c2Pal   <= !c1Fmt[1];
                oScrX   <= c1X;
                oScrY   <= c1Y;
                oR      <= c1R;
                oG      <= c1G;
                oB      <= c1B;
                oBGMSK  <= c1Msk;
            end
            c2First <= c2Adv & c1Valid & c1Res;
            if (c2First)
                c2Clut <= i_clutData;
            if (i_flushSpike) begin
                c1Spike <= 2'b00;
                c2Spike <= 2'b00;
            end
            if (texHit && o_hitCnt != '1)
                o_hitCnt <= o_hitCnt + STAT_W'(1);
            if (texMiss && o_missCnt != '1)
                o_missCnt <= o_missCnt + STAT_W'(1);
        end
    end
endmodule

// File: tb/tb_gpu_tex_pipe_ctrl_v3.sv
// tb_gpu_tex_pipe_ctrl_v3: vector table plus corner sequences, with cache/CLUT responders
// and an accept-to-output scoreboard.
module tb_gpu_tex_pipe_ctrl_v3;
    localparam int ADR_W = 19, COL_W = 9, STAT_W = 16;
    logic clk = 0, i_rst = 1;
    logic [1:0] GPU_REG_TexFormat = 0, iPixelStateSpike = 0, iUCoordLSB = 0, oPixelStateSpike;
    logic GPU_TEX_DISABLE = 0, i_flushSpike = 0, i_valid = 0, o_ready, iBGMSK = 0;
    logic [9:0] iScrX = 0, oScrX;
    logic [8:0] iScrY = 0, oScrY;
    logic [COL_W-1:0] iR = 0, iG = 0, iB = 0, oR, oG, oB;
    logic [ADR_W-1:0] iTexelAdr = 0, o_texAdr;
    logic o_texReq, i_texHit, i_texMiss, o_fillReq, i_fillDone = 0, o_valid, i_ready = 1;
    logic [15:0] i_texData, i_clutData, oTexel;
    logic [ADR_W-3:0] o_fillAdr;
    logic [7:0] o_clutIndex;
    logic oBGMSK, oTransparent, o_busy;
    logic [STAT_W-1:0] o_hitCnt, o_missCnt;

    gpu_tex_pipe_ctrl_v3 #(.ADR_W(ADR_W), .COL_W(COL_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .i_rst(i_rst), .GPU_REG_TexFormat(GPU_REG_TexFormat), .GPU_TEX_DISABLE(GPU_TEX_DISABLE),
        .i_flushSpike(i_flushSpike), .i_valid(i_valid), .o_ready(o_ready), .iPixelStateSpike(iPixelStateSpike),
        .iScrX(iScrX), .iScrY(iScrY), .iR(iR), .iG(iG), .iB(iB), .iBGMSK(iBGMSK), .iUCoordLSB(iUCoordLSB),
        .iTexelAdr(iTexelAdr), .o_texReq(o_texReq), .o_texAdr(o_texAdr), .i_texHit(i_texHit),
        .i_texMiss(i_texMiss), .i_texData(i_texData), .o_fillReq(o_fillReq), .o_fillAdr(o_fillAdr),
        .i_fillDone(i_fillDone), .o_clutIndex(o_clutIndex), .i_clutData(i_clutData), .o_valid(o_valid),
        .i_ready(i_ready), .oPixelStateSpike(oPixelStateSpike), .oScrX(oScrX), .oScrY(oScrY), .oR(oR),
        .oG(oG), .oB(oB), .oBGMSK(oBGMSK), .oTexel(oTexel), .oTransparent(oTransparent), .o_busy(o_busy),
        .o_hitCnt(o_hitCnt), .o_missCnt(o_missCnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Texture cache and CLUT models: answer one cycle after the request/index.
    logic [15:0] texMem [int];
    int missLeft [int];
    logic [15:0] clutTab [256];
    initial begin
        logic rq;
        logic [ADR_W-1:0] ra;
        logic [7:0] ci;
        i_texHit = 0; i_texMiss = 0; i_texData = 0; i_clutData = 0;
        forever begin
            @(negedge clk);
            rq = o_texReq; ra = o_texAdr; ci = o_clutIndex;
            @(posedge clk); #1;
            i_clutData = clutTab[ci];
            i_texHit = 0; i_texMiss = 0; i_texData = 0;
            if (rq && !i_rst) begin
                if (missLeft.exists(int'(ra)) && missLeft[int'(ra)] > 0) begin
                    i_texMiss = 1;
                    missLeft[int'(ra)] = missLeft[int'(ra)] - 1;
                end else begin
                    i_texHit = 1;
                    i_texData = texMem.exists(int'(ra)) ? texMem[int'(ra)] : 16'h0000;
                end
            end
        end
    end

    typedef struct {logic [9:0] x; logic [15:0] tex; logic tr; int cyc; bit lat;} sb_t;
    sb_t sb[$];
    logic [15:0] curExp = 0;
    bit latMode = 0;
    initial begin
        sb_t e;
        logic tr;
        forever begin
            @(negedge clk);
            if (!i_rst) begin
                if (o_valid && i_ready) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output actual_x=%0d required=none", oScrX);
                    end else begin
                        e = sb.pop_front();
                        chk("texel", 32'(oTexel), 32'(e.tex));
                        chk("scrX", 32'(oScrX), 32'(e.x));
                        chk("transparent", 32'(oTransparent), 32'(e.tr));
                        if (e.lat) chk("latency", cyc - e.cyc, 2);
                    end
                end
                if (i_valid && o_ready) begin
                    tr = !GPU_TEX_DISABLE && curExp[14:0] == 15'd0;
                    sb.push_back('{iScrX, curExp, tr, cyc, latMode});
                end
            end
        end
    end

    task automatic sendPix(input logic [1:0] fmt, input logic dis, input logic [1:0] u, input logic [ADR_W-1:0] adr,
                           input logic [9:0] x, input logic [1:0] spk, input logic [15:0] exp, output int waited);
        logic acc;
        GPU_REG_TexFormat = fmt; GPU_TEX_DISABLE = dis; iUCoordLSB = u; iTexelAdr = adr;
        iScrX = x; iScrY = x[8:0]; iR = x[8:0]; iG = ~x[8:0]; iB = 9'h55; iPixelStateSpike = spk;
        curExp = exp; i_valid = 1; waited = 0;
        forever begin
            @(negedge clk); acc = o_ready;
            @(posedge clk); #1;
            if (acc) break;
            waited++;
            if (waited > 200) begin
                checks++; failures++;
                $display("FAIL accept_timeout actual=stalled required=accept");
                break;
            end
        end
        i_valid = 0; iPixelStateSpike = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || o_busy) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 32'(sb.size() == 0 && !o_busy), 1);
    endtask

    task automatic doReset();
        i_rst = 1; i_valid = 0; i_fillDone = 0; i_flushSpike = 0; i_ready = 1;
        repeat (2) @(posedge clk);
        #1; i_rst = 0;
        sb.delete(); missLeft.delete();
    endtask

    task automatic doFill(input logic [ADR_W-3:0] fa, input int n);
        int t = 0;
        @(negedge clk);
        while (!o_fillReq && t < 50) begin @(negedge clk); t++; end
        chk("fill_start", 32'(o_fillReq), 1);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            chk("fillReq_held", 32'(o_fillReq), 1);
            chk("fillAdr", 32'(o_fillAdr), 32'(fa));
            chk("ready_in_fill", 32'(o_ready), 0);
        end
        @(posedge clk); #1; i_fillDone = 1;
        @(posedge clk); #1; i_fillDone = 0;
    endtask

    typedef struct {logic [1:0] fmt; logic dis; logic [1:0] u; logic [ADR_W-1:0] adr; logic [15:0] tex; logic [15:0] exp;} vec_t;
    vec_t vt[11];

    initial begin
        int w, t;
        for (int i = 0; i < 256; i++) clutTab[i] = {i[7:0], ~i[7:0]};
        doReset();
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_texReq", 32'(o_texReq), 0);
        chk("rst_fillReq", 32'(o_fillReq), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_hitCnt", 32'(o_hitCnt), 0);
        chk("rst_missCnt", 32'(o_missCnt), 0);
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_spike", 32'(oPixelStateSpike), 0);
        @(posedge clk); #1;

        // Vector table: all hits, back-to-back, i_ready=1.
        clutTab[5] = 16'h1234;
        vt[0]  = '{2'd2, 1'b0, 2'd0, 19'h00010, 16'h7C1F, 16'h7C1F};
        vt[1]  = '{2'd3, 1'b0, 2'd0, 19'h00011, 16'h8000, 16'h8000};
        vt[2]  = '{2'd2, 1'b0, 2'd0, 19'h00012, 16'h1234, 16'h1234};
        vt[3]  = '{2'd2, 1'b0, 2'd0, 19'h00013, 16'hFFFF, 16'hFFFF};
        vt[4]  = '{2'd0, 1'b0, 2'd2, 19'h00014, 16'hA5C3, 16'h1234};
        vt[5]  = '{2'd0, 1'b0, 2'd0, 19'h00015, 16'hA5C3, 16'h03FC};
        vt[6]  = '{2'd0, 1'b0, 2'd3, 19'h00016, 16'hA5C3, 16'h0AF5};
        vt[7]  = '{2'd1, 1'b0, 2'd0, 19'h00017, 16'hA5C3, 16'hC33C};
        vt[8]  = '{2'd1, 1'b0, 2'd1, 19'h00018, 16'hA5C3, 16'hA55A};
        vt[9]  = '{2'd2, 1'b1, 2'd0, 19'h00019, 16'h1111, 16'h7FFF};
        vt[10] = '{2'd0, 1'b0, 2'd1, 19'h0001A, 16'hA5C3, 16'h0CF3};
        foreach (vt[i]) texMem[int'(vt[i].adr)] = vt[i].tex;
        latMode = 1;
        foreach (vt[i]) begin
            sendPix(vt[i].fmt, vt[i].dis, vt[i].u, vt[i].adr, 10'(100 + i), 2'b00, vt[i].exp, w);
            chk("ready_b2b", w, 0);
        end
        latMode = 0;
        drain();
        chk("hitCnt_table", 32'(o_hitCnt), 10);
        chk("missCnt_table", 32'(o_missCnt), 0);

        // CLUT index output and transparent palette colour.
        clutTab[5] = 16'h8000;
        texMem[32'h30] = 16'hA5C3;
        sendPix(2'd0, 1'b0, 2'd2, 19'h00030, 10'd300, 2'b00, 16'h8000, w);
        @(negedge clk);
        chk("clutIndex", 32'(o_clutIndex), 32'h05);
        @(posedge clk); #1;
        drain();

        // Single miss, refill after 10 cycles, replay hit.
        doReset();
        texMem[32'h104] = 16'h4321;
        missLeft[32'h104] = 1;
        sendPix(2'd2, 1'b0, 2'd0, 19'h00104, 10'd400, 2'b00, 16'h4321, w);
        doFill(17'h00041, 10);
        drain();
        chk("missCnt_one", 32'(o_missCnt), 1);
        chk("hitCnt_replay", 32'(o_hitCnt), 1);

        // Replay misses again: back to FILL, pixel still output once.
        doReset();
        texMem[32'h108] = 16'h0BCD;
        missLeft[32'h108] = 2;
        sendPix(2'd2, 1'b0, 2'd0, 19'h00108, 10'd500, 2'b00, 16'h0BCD, w);
        doFill(17'h00042, 3);
        doFill(17'h00042, 3);
        drain();
        chk("missCnt_two", 32'(o_missCnt), 2);

        // Back-pressure with C2 and C1 full.
        doReset();
        clutTab[5] = 16'h1234;
        texMem[32'h50] = 16'hA5C3; texMem[32'h51] = 16'h2222; texMem[32'h52] = 16'h3333;
        i_ready = 0;
        sendPix(2'd0, 1'b0, 2'd2, 19'h00050, 10'd600, 2'b00, 16'h1234, w);
        sendPix(2'd2, 1'b0, 2'd0, 19'h00051, 10'd601, 2'b00, 16'h2222, w);
        GPU_REG_TexFormat = 2'd2; GPU_TEX_DISABLE = 0; iTexelAdr = 19'h00052; iScrX = 10'd602;
        curExp = 16'h3333; i_valid = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_ready", 32'(o_ready), 0);
            chk("stall_valid", 32'(o_valid), 1);
            chk("stall_texel", 32'(oTexel), 32'h1234);
            chk("stall_scrX", 32'(oScrX), 600);
            @(posedge clk); #1;
        end
        i_ready = 1;
        sendPix(2'd2, 1'b0, 2'd0, 19'h00052, 10'd602, 2'b00, 16'h3333, w);
        drain();

        // Reset in FILL, stray fill-done, then spike flush under stall.
        doReset();
        texMem[32'h200] = 16'h0001;
        missLeft[32'h200] = 5;
        sendPix(2'd2, 1'b0, 2'd0, 19'h00200, 10'd700, 2'b00, 16'h0001, w);
        t = 0;
        @(negedge clk);
        while (!o_fillReq && t < 50) begin @(negedge clk); t++; end
        chk("fill_before_rst", 32'(o_fillReq), 1);
        @(posedge clk); #1; i_rst = 1;
        @(posedge clk); #1; i_rst = 0;
        sb.delete(); missLeft.delete();
        @(negedge clk);
        chk("rst_mid_fillReq", 32'(o_fillReq), 0);
        chk("rst_mid_busy", 32'(o_busy), 0);
        chk("rst_mid_missCnt", 32'(o_missCnt), 0);
        @(posedge clk); #1; i_fillDone = 1;
        @(posedge clk); #1; i_fillDone = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_done_texReq", 32'(o_texReq), 0);
            chk("stray_done_fillReq", 32'(o_fillReq), 0);
            @(posedge clk); #1;
        end
        texMem[32'h300] = 16'h0777;
        i_ready = 0;
        sendPix(2'd2, 1'b0, 2'd0, 19'h00300, 10'd800, 2'b01, 16'h0777, w);
        @(posedge clk); #1;
        @(negedge clk);
        chk("spike_out", 32'(oPixelStateSpike), 1);
        @(posedge clk); #1; i_flushSpike = 1;
        @(negedge clk);
        chk("spike_flush_now", 32'(oPixelStateSpike), 0);
        @(posedge clk); #1; i_flushSpike = 0;
        @(negedge clk);
        chk("spike_flush_held", 32'(oPixelStateSpike), 0);
        chk("flush_keeps_valid", 32'(o_valid), 1);
        @(posedge clk); #1; i_ready = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
